pkt_fifo_sc: RTL and testbench
==============================

// Module: pkt_fifo_sc
// PURPOSE
//   Single-clock packet FIFO for receiver sample streams (one packet = one pulse/frame).
//   Writer appends words speculatively, commits a packet with wlast_i or drops it with wdrop_i.
//   Reader sees only committed packets, first-word-fall-through, with a per-word last flag.
//   Packets that overflow are discarded automatically. Sits between ADC/decimator and DMA packer.
// PARAMETERS
//   DWIDTH       16  data word width (1..64)
//   DEPTH        64  storage words; power of two, >=4; AWIDTH=log2(DEPTH), pointers AWIDTH+1 bits
//   AFULLOFFSET  4   afull_o when wcount >= DEPTH-AFULLOFFSET
//   AEMPTYOFFSET 1   aempty_o when rcount <= AEMPTYOFFSET
// PORTS
//   wclk_i      in  1       clock, all logic on rising edge
//   rst         in  1       synchronous, active-low reset
//   wen_i       in  1       write strobe
//   data_i      in  DWIDTH  write data
//   wlast_i     in  1       final word of packet; only meaningful with wen_i=1
//   wdrop_i     in  1       discard current uncommitted packet
//   full_o      out 1       wcount==DEPTH (includes uncommitted words)
//   afull_o     out 1       almost full
//   overflow_o  out 1       1-cycle pulse: write attempted while full
//   drop_o      out 1       1-cycle pulse: a packet was discarded (wdrop_i or overflow)
//   wcount_o    out 16      words held incl. uncommitted (zero-extended)
//   ren_i       in  1       pop head word
//   data_o      out DWIDTH  head word (valid when valid_o=1)
//   last_o      out 1       head word is last of its packet
//   valid_o     out 1       committed word available
//   empty_o     out 1       rcount==0
//   aempty_o    out 1       almost empty
//   underflow_o out 1       1-cycle pulse: ren_i while valid_o=0
//   rcount_o    out 16      committed unread words
//   pkt_count_o out 16      committed packets not fully read
// BEHAVIOUR
//   Reset (rst=0 at edge): wr_ptr, commit_ptr, rd_ptr, pkt count, error flag <= 0; outputs:
//     valid_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, all pulses 0, all counts 0.
//     Reset mid-packet discards everything, no drop_o pulse.
//   Storage DEPTH x (DWIDTH+1) {last,data}; addresses = ptr[AWIDTH-1:0]; MSB is wrap bit.
//   wcount = wr_ptr-rd_ptr, rcount = commit_ptr-rd_ptr, modulo 2^(AWIDTH+1); all from registers.
//   Write: wen_i & !full_o & !wdrop_i -> store {wlast_i,data_i} at wr_ptr, wr_ptr+1.
//     If also wlast_i and error flag clear: commit_ptr <= new wr_ptr, pkt_count+1.
//   Overflow: wen_i & full_o -> word not stored, overflow_o pulses next cycle, error flag set.
//     Errored packet: on next wen_i&wlast_i (or wdrop_i) wr_ptr <= commit_ptr, drop_o pulses, flag clears.
//   wdrop_i: wr_ptr <= commit_ptr, error flag clears, drop_o pulses next cycle; priority over
//     wen_i/wlast_i same cycle (that word discarded). Drop with zero uncommitted words: still pulses.
//   Read (FWFT): data_o/last_o = mem[rd_ptr] combinational; valid_o = (rcount!=0).
//     ren_i & valid_o -> rd_ptr+1; if last_o, pkt_count-1. ren_i & !valid_o -> no change,
//     underflow_o pulses next cycle.
//   Commit-to-visible latency: committed at edge N, valid_o=1 in cycle after edge N.
//   Commit and last-word pop same cycle: pkt_count unchanged. Write and read same cycle when
//     full: read frees slot only next cycle (full_o from registered pointers; write rejected).
//   Packet longer than DEPTH: fills FIFO, overflows, is dropped -> no deadlock.
//   Counts saturate at 16'hFFFF if AWIDTH>=16.
// TESTING
//   1 DEPTH=8: write 3 words A,B,C (wlast on C) -> valid_o 1 cycle after C; pops A,B,C, last_o only on C, pkt_count 1->0.
//   2 Write 2 words, wdrop_i -> drop_o pulse, wcount 2->0, valid_o stays 0, rcount 0.
//   3 DEPTH=8, packet of 10 words -> full_o after 8, overflow_o pulses at word 9, drop_o on wlast, wcount 0.
//   4 Committed 4-word pkt then 3-word pkt in progress -> rcount 4, wcount 7, afull_o=1 (AFULLOFFSET=4 -> >=4).
//   5 ren_i on empty -> underflow_o pulse, rd_ptr unchanged; 20 pkts of 3 words -> pointer wrap, data intact.
//   6 rst=0 mid-packet with 5 committed words -> next cycle all counts 0, empty_o=1, valid_o=0.

Source files
------------

// File: rtl/pkt_fifo_sc_if.sv
// Handshake bundle for the single-clock packet FIFO: writer side, reader side and status.
// The master modport is the producer/consumer view; slave is the FIFO itself.
interface pkt_fifo_sc_if #(
  parameter int DWIDTH = 16
);
  logic              wen_i;
  logic [DWIDTH-1:0] data_i;
  logic              wlast_i;
  logic              wdrop_i;
  logic              full_o;
  logic              afull_o;
  logic              overflow_o;
  logic              drop_o;
  logic [15:0]       wcount_o;
  logic              ren_i;
  logic [DWIDTH-1:0] data_o;
  logic              last_o;
  logic              valid_o;
  logic              empty_o;
  logic              aempty_o;
  logic              underflow_o;
  logic [15:0]       rcount_o;
  logic [15:0]       pkt_count_o;

  modport master (
    output wen_i, data_i, wlast_i, wdrop_i, ren_i,
    input  full_o, afull_o, overflow_o, drop_o, wcount_o,
    input  data_o, last_o, valid_o, empty_o, aempty_o, underflow_o, rcount_o, pkt_count_o
  );

  modport slave (
    input  wen_i, data_i, wlast_i, wdrop_i, ren_i,
    output full_o, afull_o, overflow_o, drop_o, wcount_o,
    output data_o, last_o, valid_o, empty_o, aempty_o, underflow_o, rcount_o, pkt_count_o
  );
endinterface

// File: rtl/pkt_fifo_sc.sv
// Single-clock packet FIFO: speculative writes are committed on the last word or rewound on drop/overflow,
// and the reader sees only committed packets in first-word-fall-through order.
module pkt_fifo_sc #(
  parameter int DWIDTH       = 16,
  parameter int DEPTH        = 64,
  parameter int AFULLOFFSET  = 4,
  parameter int AEMPTYOFFSET = 1
) (
  input logic          wclk_i,
  input logic          rst,
  pkt_fifo_sc_if.slave bus
);
  localparam int AWIDTH    = $clog2(DEPTH);
  localparam int CW        = AWIDTH + 1;
  localparam int AFULL_INT = DEPTH - AFULLOFFSET;
  localparam logic [CW-1:0] DEPTH_LVL  = DEPTH[CW-1:0];
  localparam logic [CW-1:0] AFULL_LVL  = AFULL_INT[CW-1:0];
  localparam logic [CW-1:0] AEMPTY_LVL = AEMPTYOFFSET[CW-1:0];

  logic [DWIDTH:0] mem [DEPTH];
  logic [CW-1:0]   wr_ptr, commit_ptr, rd_ptr, pkt_cnt;
  logic            err, overflow_q, underflow_q, drop_q;
  logic [CW-1:0]   wcount, rcount;
  logic [DWIDTH:0] head;
  logic            full, valid, accept, rewind, commit, pop, pop_last;

  assign wcount = wr_ptr - rd_ptr;
  assign rcount = commit_ptr - rd_ptr;
  assign full   = (wcount == DEPTH_LVL);
  assign valid  = (rcount != '0);
  assign head   = mem[rd_ptr[AWIDTH-1:0]];

  // A last word arriving on an errored packet, or hitting a full FIFO, ends that packet as a drop.
  assign accept   = bus.wen_i & ~full & ~bus.wdrop_i;
  assign rewind   = bus.wdrop_i | (bus.wen_i & bus.wlast_i & (err | full));
  assign commit   = accept & bus.wlast_i & ~err;
  assign pop      = bus.ren_i & valid;
  assign pop_last = pop & head[DWIDTH];

  always_ff @(posedge wclk_i) begin
    if (accept) begin
      mem[wr_ptr[AWIDTH-1:0]] <= {bus.wlast_i, bus.data_i};
    end
  end

  always_ff @(posedge wclk_i) begin
    if (!rst) begin
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      pkt_cnt     <= '0;
      err         <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      overflow_q  <= bus.wen_i & full & ~bus.wdrop_i;
      underflow_q <= bus.ren_i & ~valid;
      drop_q      <= rewind;
      if (rewind) begin
        wr_ptr <= commit_ptr;
        err    <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (commit) begin
          commit_ptr <= wr_ptr + 1'b1;
        end
        if (bus.wen_i & full) begin
          err <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (commit & ~pop_last) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end else if (pop_last & ~commit) begin
        pkt_cnt <= pkt_cnt - 1'b1;
      end
    end
  end

  // Counts are zero-extended to 16 bits, saturating only when the pointer space is wider.
  generate
    if (CW > 16) begin : g_sat
      assign bus.wcount_o    = (wcount  > CW'(16'hFFFF)) ? 16'hFFFF : wcount[15:0];
      assign bus.rcount_o    = (rcount  > CW'(16'hFFFF)) ? 16'hFFFF : rcount[15:0];
      assign bus.pkt_count_o = (pkt_cnt > CW'(16'hFFFF)) ? 16'hFFFF : pkt_cnt[15:0];
    end else begin : g_ext
      assign bus.wcount_o    = 16'(wcount);
      assign bus.rcount_o    = 16'(rcount);
      assign bus.pkt_count_o = 16'(pkt_cnt);
    end
  endgenerate

  assign bus.full_o      = full;
  assign bus.afull_o     = (wcount >= AFULL_LVL);
  assign bus.overflow_o  = overflow_q;
  assign bus.drop_o      = drop_q;
  assign bus.data_o      = head[DWIDTH-1:0];
  assign bus.last_o      = head[DWIDTH];
  assign bus.valid_o     = valid;
  assign bus.empty_o     = ~valid;
  assign bus.aempty_o    = (rcount <= AEMPTY_LVL);
  assign bus.underflow_o = underflow_q;
endmodule

// File: tb/tb_pkt_fifo_sc.sv
// Directed self-checking bench for pkt_fifo_sc with DEPTH=8: commit, drop, overflow,
// almost flags, underflow, pointer wrap, commit/pop overlap and mid-packet reset.
module tb_pkt_fifo_sc;
  localparam int DW = 16;

  logic wclk_i = 1'b0;
  logic rst    = 1'b0;
  int   tests_run  = 0;
  int   fail_count = 0;

  pkt_fifo_sc_if #(.DWIDTH(DW)) bus ();

  pkt_fifo_sc #(
    .DWIDTH(DW), .DEPTH(8), .AFULLOFFSET(4), .AEMPTYOFFSET(1)
  ) dut (
    .wclk_i(wclk_i),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 wclk_i = ~wclk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk_i);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d, input logic l);
    bus.wen_i   = 1'b1;
    bus.data_i  = d;
    bus.wlast_i = l;
    tick();
    bus.wen_i   = 1'b0;
    bus.wlast_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] d, input logic l);
    checkOutput({tag, "_valid"}, 32'(bus.valid_o), 1);
    checkOutput({tag, "_data"}, 32'(bus.data_o), 32'(d));
    checkOutput({tag, "_last"}, 32'(bus.last_o), 32'(l));
    bus.ren_i = 1'b1;
    tick();
    bus.ren_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    bus.wen_i = 1'b0; bus.data_i = '0; bus.wlast_i = 1'b0; bus.wdrop_i = 1'b0; bus.ren_i = 1'b0;
    tick(); tick();
    checkOutput("rst_valid",  32'(bus.valid_o), 0);
    checkOutput("rst_empty",  32'(bus.empty_o), 1);
    checkOutput("rst_aempty", 32'(bus.aempty_o), 1);
    checkOutput("rst_full",   32'(bus.full_o), 0);
    checkOutput("rst_afull",  32'(bus.afull_o), 0);
    checkOutput("rst_pulses", {29'd0, bus.overflow_o, bus.underflow_o, bus.drop_o}, 0);
    checkOutput("rst_wcount", 32'(bus.wcount_o), 0);
    checkOutput("rst_rcount", 32'(bus.rcount_o), 0);
    checkOutput("rst_pkt",    32'(bus.pkt_count_o), 0);
    rst = 1'b1;
    tick();

    // Three-word packet becomes visible only after its last word.
    do_write(16'h000A, 1'b0);
    checkOutput("t1_valid_a", 32'(bus.valid_o), 0);
    checkOutput("t1_wcount_a", 32'(bus.wcount_o), 1);
    do_write(16'h000B, 1'b0);
    checkOutput("t1_valid_b", 32'(bus.valid_o), 0);
    do_write(16'h000C, 1'b1);
    checkOutput("t1_valid_c", 32'(bus.valid_o), 1);
    checkOutput("t1_rcount", 32'(bus.rcount_o), 3);
    checkOutput("t1_pkt1", 32'(bus.pkt_count_o), 1);
    checkOutput("t1_aempty", 32'(bus.aempty_o), 0);
    pop_check("t1_a", 16'h000A, 1'b0);
    pop_check("t1_b", 16'h000B, 1'b0);
    checkOutput("t1_aempty1", 32'(bus.aempty_o), 1);
    pop_check("t1_c", 16'h000C, 1'b1);
    checkOutput("t1_pkt0", 32'(bus.pkt_count_o), 0);
    checkOutput("t1_empty", 32'(bus.empty_o), 1);

    // Drop of an uncommitted packet.
    do_write(16'h0021, 1'b0);
    do_write(16'h0022, 1'b0);
    checkOutput("t2_wcount2", 32'(bus.wcount_o), 2);
    bus.wdrop_i = 1'b1;
    tick();
    bus.wdrop_i = 1'b0;
    checkOutput("t2_drop", 32'(bus.drop_o), 1);
    checkOutput("t2_wcount0", 32'(bus.wcount_o), 0);
    checkOutput("t2_valid", 32'(bus.valid_o), 0);
    checkOutput("t2_rcount", 32'(bus.rcount_o), 0);
    tick();
    checkOutput("t2_drop_end", 32'(bus.drop_o), 0);

    // Ten-word packet into eight slots overflows and is discarded.
    for (int i = 0; i < 8; i++) do_write(16'(16'h0300 + i), 1'b0);
    checkOutput("t3_full", 32'(bus.full_o), 1);
    checkOutput("t3_wcount8", 32'(bus.wcount_o), 8);
    checkOutput("t3_ovf_none", 32'(bus.overflow_o), 0);
    do_write(16'h0308, 1'b0);
    checkOutput("t3_ovf", 32'(bus.overflow_o), 1);
    checkOutput("t3_wcount_hold", 32'(bus.wcount_o), 8);
    do_write(16'h0309, 1'b1);
    checkOutput("t3_drop", 32'(bus.drop_o), 1);
    checkOutput("t3_wcount0", 32'(bus.wcount_o), 0);
    checkOutput("t3_full0", 32'(bus.full_o), 0);
    checkOutput("t3_valid", 32'(bus.valid_o), 0);

    // Committed 4-word packet plus 3 in flight.
    for (int i = 0; i < 4; i++) do_write(16'(16'h0400 + i), i == 3);
    for (int i = 0; i < 3; i++) do_write(16'(16'h0410 + i), 1'b0);
    checkOutput("t4_rcount", 32'(bus.rcount_o), 4);
    checkOutput("t4_wcount", 32'(bus.wcount_o), 7);
    checkOutput("t4_afull", 32'(bus.afull_o), 1);
    checkOutput("t4_pkt", 32'(bus.pkt_count_o), 1);
    bus.wdrop_i = 1'b1;
    tick();
    bus.wdrop_i = 1'b0;
    checkOutput("t4_wcount_drop", 32'(bus.wcount_o), 4);
    for (int i = 0; i < 4; i++) pop_check("t4_pop", 16'(16'h0400 + i), i == 3);
    checkOutput("t4_empty", 32'(bus.empty_o), 1);

    // Underflow on empty, then wrap the pointers several times.
    bus.ren_i = 1'b1;
    tick();
    bus.ren_i = 1'b0;
    checkOutput("t5_underflow", 32'(bus.underflow_o), 1);
    checkOutput("t5_rcount", 32'(bus.rcount_o), 0);
    tick();
    checkOutput("t5_underflow_end", 32'(bus.underflow_o), 0);
    for (int p = 0; p < 20; p++) begin
      for (int w = 0; w < 3; w++) do_write(16'(16'h5000 + p * 3 + w), w == 2);
      for (int w = 0; w < 3; w++) pop_check("t5_wrap", 16'(16'h5000 + p * 3 + w), w == 2);
    end
    checkOutput("t5_pkt0", 32'(bus.pkt_count_o), 0);

    // Commit of one packet while the previous packet's last word is popped.
    do_write(16'h0601, 1'b1);
    checkOutput("t7_pkt1", 32'(bus.pkt_count_o), 1);
    bus.wen_i = 1'b1; bus.data_i = 16'h0602; bus.wlast_i = 1'b1; bus.ren_i = 1'b1;
    tick();
    bus.wen_i = 1'b0; bus.wlast_i = 1'b0; bus.ren_i = 1'b0;
    checkOutput("t7_pkt_same", 32'(bus.pkt_count_o), 1);
    checkOutput("t7_rcount", 32'(bus.rcount_o), 1);
    pop_check("t7_pop", 16'h0602, 1'b1);
    checkOutput("t7_pkt0", 32'(bus.pkt_count_o), 0);

    // Reset in the middle of a packet clears everything silently.
    for (int i = 0; i < 5; i++) do_write(16'(16'h0700 + i), i == 4);
    do_write(16'h0710, 1'b0);
    do_write(16'h0711, 1'b0);
    checkOutput("t6_pre_rcount", 32'(bus.rcount_o), 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("t6_wcount", 32'(bus.wcount_o), 0);
    checkOutput("t6_rcount", 32'(bus.rcount_o), 0);
    checkOutput("t6_pkt", 32'(bus.pkt_count_o), 0);
    checkOutput("t6_empty", 32'(bus.empty_o), 1);
    checkOutput("t6_valid", 32'(bus.valid_o), 0);
    checkOutput("t6_drop", 32'(bus.drop_o), 0);
    tick();
    checkOutput("t6_drop_after", 32'(bus.drop_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end
endmodule
